// File: rtl/stream_mem_arbiter_pkg.sv
// stream_mem_arbiter_pkg
// Shared types and helpers for the stream memory arbiter.
//   idx_t    : requester index, wide enough for NumPortsCfg ports (minimum 1 bit)
//   rr_next  : cyclic increment of a requester index
// NumPortsCfg sizes idx_t. The top-level NumPorts parameter defaults to it, so
// changing the port count means changing this constant.
package stream_mem_arbiter_pkg;

    localparam int unsigned NumPortsCfg = 4;
    localparam int unsigned IdxWidth    = (NumPortsCfg > 1) ? $clog2(NumPortsCfg) : 1;

    typedef logic [IdxWidth-1:0] idx_t;

    // Next index in round-robin order. It wraps to 0 after num_ports-1.
    function automatic idx_t rr_next(input idx_t idx, input int unsigned num_ports);
        if (32'(idx) + 32'd1 >= num_ports) begin
            return '0;
        end
        return idx + idx_t'(1);
    endfunction

endpackage

// File: rtl/fifo_v3.sv
// fifo_v3
// Reduced common_cells-style synchronous FIFO. It has no fall-through, so data
// pushed in one cycle is visible at data_o from the next cycle on.
//   clk_i   : clock
//   rst_ni  : asynchronous reset, active-low
//   full_o  : no free entry
//   empty_o : no valid entry
//   data_i  : write data, taken when push_i and not full
//   push_i  : write request
//   data_o  : head entry (valid when not empty)
//   pop_i   : remove head entry, ignored when empty
module fifo_v3 #(
    parameter int unsigned DEPTH = 4,
    parameter type         dtype = logic
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic full_o,
    output logic empty_o,
    input  dtype data_i,
    input  logic push_i,
    output dtype data_o,
    input  logic pop_i
);

    localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW  = $clog2(DEPTH + 1);
    localparam logic [AddrW-1:0] LastAddr = AddrW'(DEPTH - 1);

    dtype             mem [DEPTH];
    logic [AddrW-1:0] rd_ptr;
    logic [AddrW-1:0] wr_ptr;
    logic [CntW-1:0]  count;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count == CntW'(DEPTH));
    assign empty_o = (count == '0);
    assign data_o  = mem[rd_ptr];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= (wr_ptr == LastAddr) ? '0 : wr_ptr + AddrW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= (rd_ptr == LastAddr) ? '0 : rd_ptr + AddrW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CntW'(1);
                2'b01:   count <= count - CntW'(1);
                default: count <= count;
            endcase
        end
    end

    // The storage array has no reset. Only the pointers define which entries are valid.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wr_ptr] <= data_i;
        end
    end

endmodule

// File: rtl/stream_mem_arbiter.sv
// stream_mem_arbiter
// Shares one in-order memory port among NumPorts stream requesters. Grants are
// round-robin. A port is granted only while it holds a free response-buffer
// credit, so the memory response needs no backpressure.
//   clk, rst_n                   : clock, asynchronous active-high reset
//   req_i/req_valid_i/req_ready_o : per-port request streams
//   resp_o/resp_valid_o/resp_ready_i : per-port response streams
//   mem_req_o/mem_req_valid_o/mem_req_ready_i : shared memory request port
//   mem_resp_i/mem_resp_valid_i  : in-order memory response pulse
//   idle_o                       : nothing outstanding and all buffers empty
//   err_o                        : sticky, a response arrived with nothing outstanding
module stream_mem_arbiter
    import stream_mem_arbiter_pkg::*;
#(
    parameter int unsigned NumPorts       = NumPortsCfg,
    parameter int unsigned DataWidth      = 16,
    parameter int unsigned RespDepth      = 2,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NumPorts-1:0][DataWidth-1:0] req_i,
    input  logic [NumPorts-1:0]                req_valid_i,
    output logic [NumPorts-1:0]                req_ready_o,
    output logic [NumPorts-1:0][DataWidth-1:0] resp_o,
    output logic [NumPorts-1:0]                resp_valid_o,
    input  logic [NumPorts-1:0]                resp_ready_i,
    output logic [DataWidth-1:0]               mem_req_o,
    output logic                               mem_req_valid_o,
    input  logic                               mem_req_ready_i,
    input  logic [DataWidth-1:0]               mem_resp_i,
    input  logic                               mem_resp_valid_i,
    output logic                               idle_o,
    output logic                               err_o
);

    localparam int unsigned CreditW = $clog2(RespDepth + 1);
    localparam int unsigned OutW    = $clog2(MaxOutstanding + 1);

    typedef logic [DataWidth-1:0] data_t;

    logic [CreditW-1:0]  credit [NumPorts];
    logic [OutW-1:0]     outstanding;
    idx_t                rr_ptr;
    logic                hold;
    idx_t                hold_idx;
    logic                err_q;

    logic [NumPorts-1:0] eligible;
    logic                can_issue;
    idx_t                grant;
    idx_t                cand;
    logic                found;
    logic                issue;

    logic                rst_active_low;
    logic                id_full;
    logic                id_empty;
    idx_t                id_head;
    logic                resp_fire;

    logic [NumPorts-1:0] buf_full;
    logic [NumPorts-1:0] buf_empty;
    logic [NumPorts-1:0] buf_push;
    logic [NumPorts-1:0] buf_pop;

    // The FIFOs use an active-low reset.
    assign rst_active_low = ~rst_n;

    assign can_issue = (outstanding < OutW'(MaxOutstanding)) && !id_full;

    always_comb begin
        for (int p = 0; p < NumPorts; p++) begin
            eligible[p] = req_valid_i[p] && (credit[p] < CreditW'(RespDepth)) && can_issue;
        end
    end

    // Cyclic search starting at rr_ptr. While the memory port stalls, the grant
    // stays on the stalled port so that mem_req_o does not change under the
    // pending request.
    always_comb begin
        cand  = rr_ptr;
        grant = rr_ptr;
        found = 1'b0;
        for (int i = 0; i < NumPorts; i++) begin
            if (!found && eligible[cand]) begin
                found = 1'b1;
                grant = cand;
            end
            cand = rr_next(cand, NumPorts);
        end
        if (hold && eligible[hold_idx]) begin
            grant = hold_idx;
        end
    end

    assign mem_req_valid_o = |eligible;
    assign mem_req_o       = req_i[grant];
    assign issue           = mem_req_valid_o && mem_req_ready_i;

    always_comb begin
        for (int p = 0; p < NumPorts; p++) begin
            req_ready_o[p] = mem_req_valid_o && mem_req_ready_i && (grant == idx_t'(p));
        end
    end

    // A response with an empty ID FIFO is spurious. It is dropped and only raises err_o.
    assign resp_fire = mem_resp_valid_i && !id_empty;

    always_comb begin
        for (int p = 0; p < NumPorts; p++) begin
            buf_push[p] = resp_fire && (id_head == idx_t'(p)) && !buf_full[p];
            buf_pop[p]  = !buf_empty[p] && resp_ready_i[p];
        end
    end

    assign resp_valid_o = ~buf_empty;
    assign idle_o       = (outstanding == '0) && (&buf_empty);
    assign err_o        = err_q;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            rr_ptr      <= '0;
            outstanding <= '0;
            hold        <= 1'b0;
            hold_idx    <= '0;
            err_q       <= 1'b0;
            for (int p = 0; p < NumPorts; p++) begin
                credit[p] <= '0;
            end
        end else begin
            if (issue) begin
                rr_ptr <= rr_next(grant, NumPorts);
            end
            hold     <= mem_req_valid_o && !mem_req_ready_i;
            hold_idx <= grant;
            case ({issue, resp_fire})
                2'b10:   outstanding <= outstanding + OutW'(1);
                2'b01:   outstanding <= outstanding - OutW'(1);
                default: outstanding <= outstanding;
            endcase
            if (mem_resp_valid_i && id_empty) begin
                err_q <= 1'b1;
            end
            // A credit is reserved at issue and returned when the consumer takes the response.
            for (int p = 0; p < NumPorts; p++) begin
                case ({issue && (grant == idx_t'(p)), buf_pop[p]})
                    2'b10:   credit[p] <= credit[p] + CreditW'(1);
                    2'b01:   credit[p] <= credit[p] - CreditW'(1);
                    default: credit[p] <= credit[p];
                endcase
            end
        end
    end

    // Port index of every issued request, in issue order. Memory answers in order.
    fifo_v3 #(
        .DEPTH (MaxOutstanding),
        .dtype (idx_t)
    ) u_id_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_active_low),
        .full_o  (id_full),
        .empty_o (id_empty),
        .data_i  (grant),
        .push_i  (issue),
        .data_o  (id_head),
        .pop_i   (resp_fire)
    );

    for (genvar p = 0; p < NumPorts; p++) begin : g_resp_buf
        fifo_v3 #(
            .DEPTH (RespDepth),
            .dtype (data_t)
        ) u_resp_buf (
            .clk_i   (clk),
            .rst_ni  (rst_active_low),
            .full_o  (buf_full[p]),
            .empty_o (buf_empty[p]),
            .data_i  (mem_resp_i),
            .push_i  (buf_push[p]),
            .data_o  (resp_o[p]),
            .pop_i   (buf_pop[p])
        );
    end

endmodule

// File: tb/tb_stream_mem_arbiter.sv
// tb_stream_mem_arbiter
// Directed bench for stream_mem_arbiter. It contains an in-order memory model
// with programmable latency and a per-port scoreboard of issued payloads.
module tb_stream_mem_arbiter;

    localparam int NP = 4;
    localparam int DW = 16;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NP-1:0][DW-1:0]  req_i;
    logic [NP-1:0]          req_valid_i;
    logic [NP-1:0]          req_ready_o;
    logic [NP-1:0][DW-1:0]  resp_o;
    logic [NP-1:0]          resp_valid_o;
    logic [NP-1:0]          resp_ready_i;
    logic [DW-1:0]          mem_req_o;
    logic                   mem_req_valid_o;
    logic                   mem_req_ready_i;
    logic [DW-1:0]          mem_resp_i;
    logic                   mem_resp_valid_i;
    logic                   idle_o;
    logic                   err_o;

    stream_mem_arbiter #(
        .NumPorts       (NP),
        .DataWidth      (DW),
        .RespDepth      (2),
        .MaxOutstanding (4)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_i            (req_i),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .resp_o           (resp_o),
        .resp_valid_o     (resp_valid_o),
        .resp_ready_i     (resp_ready_i),
        .mem_req_o        (mem_req_o),
        .mem_req_valid_o  (mem_req_valid_o),
        .mem_req_ready_i  (mem_req_ready_i),
        .mem_resp_i       (mem_resp_i),
        .mem_resp_valid_i (mem_resp_valid_i),
        .idle_o           (idle_o),
        .err_o            (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } mem_item_t;

    mem_item_t     memq[$];
    int            cycle;
    int            last_due;
    int            lat_min;
    int            lat_max;
    logic          inject_spurious;

    logic          last_mem_valid;
    logic          last_issue;
    logic [DW-1:0] last_payload;
    logic [NP-1:0] last_req_ready;
    int            last_grant;
    int            grant_cnt[NP];
    logic [11:0]   seq[NP];

    logic [DW-1:0] sb_data[NP][16];
    int            sb_wr[NP];
    int            sb_rd[NP];
    int            sb_cnt[NP];

    int            checks;
    int            errors;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One clock cycle. The memory model drives its response, the bench samples the
    // settled outputs, clocks, then books the issue and reloads the payload of the granted port.
    task automatic applyStimulus();
        int lat;
        int due;
        mem_resp_valid_i = 1'b0;
        mem_resp_i       = '0;
        if (inject_spurious) begin
            mem_resp_valid_i = 1'b1;
            mem_resp_i       = 16'hDEAD;
        end else if (memq.size() > 0 && memq[0].due <= cycle) begin
            mem_resp_valid_i = 1'b1;
            mem_resp_i       = memq[0].data;
        end
        #1;
        last_mem_valid = mem_req_valid_o;
        last_issue     = mem_req_valid_o && mem_req_ready_i;
        last_payload   = mem_req_o;
        last_req_ready = req_ready_o;
        last_grant     = -1;
        for (int p = 0; p < NP; p++) begin
            if (req_ready_o[p]) last_grant = p;
        end
        for (int p = 0; p < NP; p++) begin
            if (resp_valid_o[p] && resp_ready_i[p]) begin
                checkOutput($sformatf("resp%0d_expected", p), 32'(sb_cnt[p] > 0), 32'd1);
                if (sb_cnt[p] > 0) begin
                    checkOutput($sformatf("resp%0d_data", p), 32'(resp_o[p]), 32'(sb_data[p][sb_rd[p] % 16]));
                    sb_rd[p]++;
                    sb_cnt[p]--;
                end
            end
        end
        @(posedge clk);
        #1;
        if (mem_resp_valid_i && !inject_spurious) void'(memq.pop_front());
        mem_resp_valid_i = 1'b0;
        if (last_issue) begin
            lat = $urandom_range(lat_max, lat_min);
            due = cycle + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            memq.push_back('{data: last_payload, due: due});
            if (last_grant >= 0) begin
                grant_cnt[last_grant]++;
                sb_data[last_grant][sb_wr[last_grant] % 16] = last_payload;
                sb_wr[last_grant]++;
                sb_cnt[last_grant]++;
                seq[last_grant]       = seq[last_grant] + 12'd1;
                req_i[last_grant]     = {4'(last_grant), seq[last_grant]};
            end
        end
        cycle++;
    endtask

    task automatic clearGrantCounts();
        for (int p = 0; p < NP; p++) grant_cnt[p] = 0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        req_valid_i     = '0;
        resp_ready_i    = '1;
        mem_req_ready_i = 1'b1;
        while ((!idle_o || memq.size() > 0) && n < 200) begin
            applyStimulus();
            n++;
        end
        checkOutput({tag, "_drain_idle"}, 32'(idle_o), 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int hs;
        int n;
        int prev;
        int order_err;
        int lock_err;
        int issues;
        logic mv[12];
        int requested;
        int issued;

        checks = 0;
        errors = 0;
        rst_n            = 1'b1;
        req_valid_i      = '0;
        resp_ready_i     = '0;
        mem_req_ready_i  = 1'b0;
        mem_resp_valid_i = 1'b0;
        mem_resp_i       = '0;
        inject_spurious  = 1'b0;
        lat_min  = 1;
        lat_max  = 1;
        cycle    = 0;
        last_due = -1;
        for (int p = 0; p < NP; p++) begin
            seq[p]    = '0;
            req_i[p]  = {4'(p), 12'd0};
            sb_wr[p]  = 0;
            sb_rd[p]  = 0;
            sb_cnt[p] = 0;
        end
        clearGrantCounts();

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_idle", 32'(idle_o), 32'd1);
        checkOutput("reset_err", 32'(err_o), 32'd0);
        checkOutput("reset_resp_valid", 32'(resp_valid_o), 32'd0);
        checkOutput("reset_mem_valid", 32'(mem_req_valid_o), 32'd0);
        checkOutput("reset_req_ready", 32'(req_ready_o), 32'd0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;

        // Single port, latency 1
        $display("[TB] single port latency 1");
        req_i[0]        = 16'hA5A5;
        req_valid_i     = 4'b0001;
        mem_req_ready_i = 1'b1;
        applyStimulus();
        checkOutput("single_mem_valid", 32'(last_mem_valid), 32'd1);
        checkOutput("single_mem_payload", 32'(last_payload), 32'hA5A5);
        checkOutput("single_req_ready", 32'(last_req_ready), 32'b0001);
        req_valid_i = '0;
        checkOutput("single_no_bypass", 32'(resp_valid_o), 32'd0);
        checkOutput("single_busy", 32'(idle_o), 32'd0);
        applyStimulus();
        checkOutput("single_resp_valid", 32'(resp_valid_o), 32'b0001);
        checkOutput("single_resp_data", 32'(resp_o[0]), 32'hA5A5);
        resp_ready_i = '1;
        applyStimulus();
        checkOutput("single_idle_again", 32'(idle_o), 32'd1);

        // Fairness: rr_ptr is now 1, so the rotation starts at port 1
        $display("[TB] fairness");
        clearGrantCounts();
        req_valid_i = '1;
        hs = 0; n = 0; prev = 0; order_err = 0;
        while (hs < 100 && n < 200) begin
            applyStimulus();
            n++;
            if (last_issue) begin
                if (last_grant != (prev + 1) % NP) order_err++;
                prev = last_grant;
                hs++;
            end
        end
        checkOutput("fair_handshakes", 32'(hs), 32'd100);
        checkOutput("fair_order_errors", 32'(order_err), 32'd0);
        for (int p = 0; p < NP; p++) checkOutput($sformatf("fair_port%0d_grants", p), 32'(grant_cnt[p]), 32'd25);
        drain("fair");

        // Credit stall on port 1
        $display("[TB] credit stall");
        clearGrantCounts();
        req_valid_i  = '1;
        resp_ready_i = 4'b1101;
        hs = 0;
        repeat (20) begin
            applyStimulus();
            if (last_issue) hs++;
        end
        checkOutput("stall_port1_grants", 32'(grant_cnt[1]), 32'd2);
        checkOutput("stall_total_grants", 32'(hs), 32'd20);
        checkOutput("stall_port1_ready", 32'(last_req_ready[1]), 32'd0);
        resp_ready_i = '1;
        clearGrantCounts();
        repeat (8) applyStimulus();
        checkOutput("stall_port1_resumes", 32'(grant_cnt[1] > 0), 32'd1);
        drain("stall");

        // Grant lock: first set rr_ptr to 3 by issuing once from port 2
        $display("[TB] grant lock");
        req_valid_i = 4'b0100;
        applyStimulus();
        checkOutput("prime_grant", 32'(last_grant), 32'd2);
        drain("prime");
        req_i[2]        = 16'h2222;
        req_valid_i     = 4'b0100;
        mem_req_ready_i = 1'b0;
        applyStimulus();
        checkOutput("lock_first_payload", 32'(last_payload), 32'h2222);
        req_i[0]    = 16'h0AAA;
        req_valid_i = 4'b0101;
        lock_err = 0;
        repeat (5) begin
            applyStimulus();
            if (!last_mem_valid || last_payload !== 16'h2222 || last_req_ready !== 4'b0000) lock_err++;
        end
        checkOutput("lock_hold_errors", 32'(lock_err), 32'd0);
        mem_req_ready_i = 1'b1;
        applyStimulus();
        checkOutput("lock_release_grant", 32'(last_grant), 32'd2);
        checkOutput("lock_release_payload", 32'(last_payload), 32'h2222);
        req_valid_i = 4'b0001;
        applyStimulus();
        checkOutput("lock_next_grant", 32'(last_grant), 32'd0);
        checkOutput("lock_next_payload", 32'(last_payload), 32'h0AAA);
        drain("lock");

        // Outstanding limit with a 10-cycle memory
        $display("[TB] outstanding limit");
        lat_min = 10;
        lat_max = 10;
        req_valid_i = '1;
        issues = 0;
        for (int s = 0; s < 12; s++) begin
            applyStimulus();
            mv[s] = last_mem_valid;
            if (s < 10 && last_issue) issues++;
        end
        checkOutput("outst_issues", 32'(issues), 32'd4);
        checkOutput("outst_valid_step4", 32'(mv[4]), 32'd0);
        checkOutput("outst_valid_step10", 32'(mv[10]), 32'd0);
        checkOutput("outst_valid_step11", 32'(mv[11]), 32'd1);
        drain("outst");

        // Random traffic
        $display("[TB] random traffic");
        lat_min = 1;
        lat_max = 8;
        requested = 0;
        issued = 0;
        n = 0;
        req_valid_i = '0;
        while (issued < 10000 && n < 60000) begin
            for (int p = 0; p < NP; p++) begin
                if (!req_valid_i[p] && requested < 10000 && $urandom_range(1, 0) == 1) begin
                    req_valid_i[p] = 1'b1;
                    requested++;
                end
                resp_ready_i[p] = ($urandom_range(3, 0) != 0);
            end
            mem_req_ready_i = ($urandom_range(3, 0) != 0);
            applyStimulus();
            n++;
            if (last_issue && last_grant >= 0) begin
                req_valid_i[last_grant] = 1'b0;
                issued++;
            end
        end
        checkOutput("random_issued", 32'(issued), 32'd10000);
        drain("random");
        for (int p = 0; p < NP; p++) checkOutput($sformatf("random_sb%0d_empty", p), 32'(sb_cnt[p]), 32'd0);
        checkOutput("random_err", 32'(err_o), 32'd0);

        // Spurious response at idle
        $display("[TB] spurious response");
        inject_spurious = 1'b1;
        applyStimulus();
        inject_spurious = 1'b0;
        checkOutput("spurious_err", 32'(err_o), 32'd1);
        checkOutput("spurious_no_resp", 32'(resp_valid_o), 32'd0);
        checkOutput("spurious_idle", 32'(idle_o), 32'd1);
        applyStimulus();
        checkOutput("spurious_err_sticky", 32'(err_o), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stream_mem_arbiter.md
Name: stream_mem_arbiter

Overview:
- Shares one fixed-order memory port among NumPorts stream requesters. The memory port has the same req/resp handshake as the stream_to_mem memory side.
- Arbitrates requests round-robin and records the port index of each issued request in order.
- Steers each in-order memory response to the issuing port's response buffer.
- Grants a port only when response buffer space is reserved for it, because mem_resp_valid_i has no backpressure.

Parameters:
- NumPorts, 4, number of requesters (≥2)
- DataWidth, 16, width of request and response payload
- RespDepth, 2, per-port response buffer depth, which is also the per-port credit limit (≥1)
- MaxOutstanding, 4, maximum requests issued to memory and not yet answered (≥1)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-high
- req_i  in  NumPorts x DataWidth  per-port request payload
- req_valid_i  in  NumPorts  per-port request valid
- req_ready_o  out  NumPorts  per-port request ready
- resp_o  out  NumPorts x DataWidth  per-port response payload
- resp_valid_o  out  NumPorts  per-port response valid
- resp_ready_i  in  NumPorts  per-port response ready
- mem_req_o  out  DataWidth  memory request payload
- mem_req_valid_o  out  1  memory request valid
- mem_req_ready_i  in  1  memory request ready
- mem_resp_i  in  DataWidth  memory response payload
- mem_resp_valid_i  in  1  single-cycle response pulse, in request order, latency ≥1 cycle
- idle_o  out  1  no outstanding requests and all response buffers empty
- err_o  out  1  sticky: response received with no outstanding request

Behaviour:
- Reset (rst_n high): all credits, the outstanding count and the rr pointer are 0; ID FIFO and response buffers are empty; resp_valid_o = 0, err_o = 0, idle_o = 1.
- Eligibility: port p is eligible when req_valid_i[p] && credit[p] < RespDepth && outstanding < MaxOutstanding.
- Grant (combinational, zero latency): the first eligible port at or after rr_ptr, searching cyclically.
  - mem_req_valid_o = any port eligible.
  - mem_req_o = req_i[grant].
  - req_ready_o[p] = (grant == p) && mem_req_ready_i.
  - All req_ready_o bits are 0 when nothing is eligible.
- Grant lock: while mem_req_valid_o && !mem_req_ready_i, the grant is held on the same port. The payload must stay stable, so no re-arbitration occurs even if a higher-priority port becomes valid. Eligibility cannot drop during a stall, because credits and outstanding only decrease.
- Issue handshake (mem_req_valid_o && mem_req_ready_i):
  - push grant index into the ID FIFO (depth MaxOutstanding);
  - credit[grant]++ and outstanding++;
  - rr_ptr = grant+1, wrapping to 0 after NumPorts-1.
  - Without a handshake, rr_ptr does not change.
- Response (mem_resp_valid_i):
  - pop the head index h from the ID FIFO, outstanding--;
  - write mem_resp_i into buffer[h]. It cannot overflow, because the credit was reserved at issue.
  - If the ID FIFO is empty: drop the response, set err_o (cleared only by reset), leave counters unchanged.
- Response delivery: resp_valid_o[p] = buffer[p] not empty, and resp_o[p] = buffer[p] head. On resp_valid_o[p] && resp_ready_i[p]: pop buffer[p], credit[p]--.
- Simultaneous events:
  - credit inc and dec on the same port in one cycle leaves credit unchanged;
  - issue and response in the same cycle leave outstanding unchanged.
  - Responses never bypass an empty buffer; a buffer-to-output latency of ≥1 cycle is required.
- Counter widths: credit is $clog2(RespDepth+1) bits, outstanding is $clog2(MaxOutstanding+1) bits. Both saturate by construction, because issue is gated.
- Ordering: responses per port return in issue order. There is no ordering relation across ports.
- idle_o = (outstanding == 0) && all buffers empty.
- Reset mid-operation: all in-flight state is discarded immediately. Memory responses arriving after reset release with outstanding == 0 set err_o.

Decomposition:
- Package stream_mem_arbiter_pkg holds:
  - port index type idx_t (width $clog2(NumPorts), minimum 1);
  - function rr_next(idx, NumPorts) for cyclic increment.
- Payload type is logic [DataWidth-1:0] and is declared locally.
- Sub-modules are the existing common_cells fifo_v3:
  - one instance as the ID FIFO (data idx_t, depth MaxOutstanding);
  - NumPorts instances as response buffers (depth RespDepth), via generate.
- Arbiter and credit logic stay in the top module.

Test Plan:
- Single port, latency 1: port 0 sends 0xA5A5, memory ready=1 → mem_req_o=0xA5A5 in the same cycle, resp_o[0]=0xA5A5 valid 2 cycles later, idle_o returns to 1.
- Fairness: all 4 ports continuously valid, mem ready=1, resp_ready=1 → grants cycle 0,1,2,3,0… with exactly 25 grants per port over 100 handshakes.
- Credit stall: RespDepth=2, port 1 resp_ready=0 → port 1 gets 2 grants and then req_ready_o[1] stays 0 while ports 0/2/3 keep being served. Raising resp_ready → port 1 resumes.
- Grant lock: port 2 granted with mem_req_ready=0 for 5 cycles while port 0 raises valid → mem_req_o holds port 2 data; the next grant goes to port 3 or 0 per rr order.
- Outstanding limit: MaxOutstanding=4, memory latency 10 cycles → mem_req_valid_o drops after 4 issues and reasserts the cycle after the first response.
- Error and random: a spurious mem_resp_valid_i at idle → err_o=1 with no resp_valid_o. 10000 random requests with random readies and latencies 1–8 → scoreboard matches all data per port, err_o stays 0.
